tournament_bp: RTL
==================

Name: tournament_bp

Overview:
- Parametrised tournament branch predictor for the fetch stage, combining three predictors:
  - a gshare global predictor (GHR xor PC indexed PHT);
  - a two-level local predictor (per-PC history table feeding a local PHT);
  - a per-PC chooser table that selects between them.
- Keeps a speculative GHR, shifted at fetch and repaired on execute-stage mispredict.
- Tables are trained at commit.
- Tables are cleared by a multi-cycle init sweep after reset, so they map onto RAM.

Parameters:
- PC_W, 32: PC width.
- GHR_W, 8: global history bits; global PHT has 2^GHR_W entries.
- LHR_W, 8: local history bits per BHT entry; local PHT has 2^LHR_W entries.
- BHT_IDX_W, 6: local BHT index bits; 2^BHT_IDX_W entries.
- CH_IDX_W, 8: chooser index bits; 2^CH_IDX_W entries.
- Legality: PC_W >= max(GHR_W, BHT_IDX_W, CH_IDX_W) + 2.

Ports:
- clk_i  in  1  clock.
- rst  in  1  reset.
- f_valid_i  in  1  fetch slot valid.
- f_is_branch_i  in  1  fetched instruction is conditional branch.
- f_pc_i  in  PC_W  fetch PC.
- f_pred_taken_o  out  1  final prediction.
- f_pred_global_o  out  1  global component prediction.
- f_pred_local_o  out  1  local component prediction.
- f_ghr_o  out  GHR_W  GHR value used for this prediction.
- rec_valid_i  in  1  mispredict repair.
- rec_ghr_i  in  GHR_W  GHR snapshot of the mispredicted branch.
- rec_taken_i  in  1  resolved direction.
- u_valid_i  in  1  commit training valid.
- u_pc_i  in  PC_W  committed branch PC.
- u_ghr_i  in  GHR_W  GHR snapshot carried with the branch.
- u_taken_i  in  1  resolved direction.
- u_pred_global_i  in  1  global prediction carried with the branch.
- u_pred_local_i  in  1  local prediction carried with the branch.
- init_busy_o  out  1  init sweep in progress.
- cnt_update_o  out  32  committed branch count.
- cnt_mispred_o  out  32  committed mispredict count.

Behaviour:
- Reset is synchronous, active-high: reset rst, synchronous, active-high; clock clk_i.
- Reset values:
  - GHR = 0, sweep index = 0, state = INIT.
  - cnt_update_o = 0, cnt_mispred_o = 0.
  - init_busy_o = 1 from the first cycle after rst is sampled.
- FSM states: INIT and RUN.
- INIT:
  - Lasts exactly N = 2^max(GHR_W, LHR_W, BHT_IDX_W, CH_IDX_W) cycles.
  - On cycle i, entry (i mod depth) of every table is written:
    - global and local PHT = 2'b01;
    - BHT = 0;
    - chooser = 2'b10 (weakly global).
  - After index N-1, the FSM moves to RUN and init_busy_o drops the next cycle.
  - During INIT, all f_pred_*_o = 0, f_ghr_o = GHR, and u_valid_i, rec_valid_i and fetch GHR shifts are ignored.
- rst during INIT or RUN restarts the sweep at index 0 and clears GHR and the counters.
- Indexing:
  - gidx = f_pc_i[GHR_W+1:2] ^ GHR.
  - bidx = f_pc_i[BHT_IDX_W+1:2].
  - lidx = BHT[bidx].
  - cidx = f_pc_i[CH_IDX_W+1:2].
  - The same formulas apply on the update side, using u_pc_i and u_ghr_i.
- Prediction (RUN) is combinational, same cycle:
  - f_pred_global_o = gPHT[gidx][1].
  - f_pred_local_o = lPHT[lidx][1].
  - f_pred_taken_o = chooser[cidx][1] ? global : local.
  - Outputs are valid regardless of f_valid_i.
- GHR update at the clock edge, in priority order:
  1. rec_valid_i: GHR <= {rec_ghr_i[GHR_W-2:0], rec_taken_i}.
  2. else if f_valid_i & f_is_branch_i: GHR <= {GHR[GHR_W-2:0], f_pred_taken_o}.
  3. else hold.
- Training (RUN, u_valid_i):
  - Global PHT entry: 2-bit saturating counter, +1 if u_taken_i, else -1. Clamps at 2'b11 and 2'b00.
  - Local PHT entry at the old BHT[bidx]: same counter rule.
  - BHT[bidx] <= {old[LHR_W-2:0], u_taken_i}.
  - Chooser:
    - global correct and local wrong: +1, saturating at 11;
    - local correct and global wrong: -1, saturating at 00;
    - otherwise: no change.
  - final_pred = chooser[cidx][1] (pre-update value) ? u_pred_global_i : u_pred_local_i.
  - cnt_update_o += 1 on each valid update.
  - cnt_mispred_o += 1 when final_pred != u_taken_i.
  - Both counters wrap modulo 2^32.
- Same-cycle read/write to the same entry: the prediction sees the pre-update value (read-before-write). The written value is visible the next cycle.
- Update and recovery in the same cycle are independent, and both apply.

Test Plan:
- Reset sweep, default parameters: 1-cycle rst → init_busy_o = 1 for exactly 256 cycles, then 0. All predictions 0 throughout. chooser[any][1] = 1 after init.
- Rst pulsed at sweep cycle 100 → sweep restarts; init_busy_o stays high a further 256 cycles. u_valid_i pulses during init leave cnt_update_o = 0.
- Global saturation, PC = 0x100, u_ghr_i = 0, 3 taken updates → gPHT goes 01→10→11→11. f_pred_global_o = 1 with f_pc_i = 0x100 when GHR = 0.
- Chooser training, PC = 0x200:
  - 2 updates with global = correct, local = wrong → chooser 11.
  - Then 3 updates with local correct, global wrong → 00; f_pred_taken_o follows f_pred_local_o.
- GHR repair: GHR = 0x5A; same cycle rec_valid_i = 1, rec_ghr_i = 0x0F, rec_taken_i = 0, plus fetch branch → GHR = 0x1E (recovery wins). Next fetch branch with prediction 1 → 0x3D.
- Local pattern, PC = 0x300, alternating T/N for 40 updates → f_pred_local_o matches the next outcome. cnt_mispred_o stops incrementing after warm-up. cnt_update_o = 40.

Source files
------------

// File: rtl/tournament_bp_if.sv
// Fetch, repair, commit-training and status signals of the tournament branch predictor.
// The core front end (or a bench) drives as master; the predictor attaches as slave.
interface tournament_bp_if #(
  parameter int PC_W  = 32,
  parameter int GHR_W = 8
);
  logic             f_valid_i;
  logic             f_is_branch_i;
  logic [PC_W-1:0]  f_pc_i;
  logic             f_pred_taken_o;
  logic             f_pred_global_o;
  logic             f_pred_local_o;
  logic [GHR_W-1:0] f_ghr_o;

  logic             rec_valid_i;
  logic [GHR_W-1:0] rec_ghr_i;
  logic             rec_taken_i;

  logic             u_valid_i;
  logic [PC_W-1:0]  u_pc_i;
  logic [GHR_W-1:0] u_ghr_i;
  logic             u_taken_i;
  logic             u_pred_global_i;
  logic             u_pred_local_i;

  logic             init_busy_o;
  logic [31:0]      cnt_update_o;
  logic [31:0]      cnt_mispred_o;

  modport master (
    output f_valid_i, f_is_branch_i, f_pc_i,
           rec_valid_i, rec_ghr_i, rec_taken_i,
           u_valid_i, u_pc_i, u_ghr_i, u_taken_i, u_pred_global_i, u_pred_local_i,
    input  f_pred_taken_o, f_pred_global_o, f_pred_local_o, f_ghr_o,
           init_busy_o, cnt_update_o, cnt_mispred_o
  );

  modport slave (
    input  f_valid_i, f_is_branch_i, f_pc_i,
           rec_valid_i, rec_ghr_i, rec_taken_i,
           u_valid_i, u_pc_i, u_ghr_i, u_taken_i, u_pred_global_i, u_pred_local_i,
    output f_pred_taken_o, f_pred_global_o, f_pred_local_o, f_ghr_o,
           init_busy_o, cnt_update_o, cnt_mispred_o
  );
endinterface

// File: rtl/tournament_bp.sv
// Tournament branch predictor: gshare + two-level local, arbitrated by a per-PC chooser.
// Speculative GHR repaired on mispredict; tables trained at commit and cleared by an init sweep.
module tournament_bp #(
  parameter int PC_W      = 32,
  parameter int GHR_W     = 8,
  parameter int LHR_W     = 8,
  parameter int BHT_IDX_W = 6,
  parameter int CH_IDX_W  = 8
) (
  input  logic           clk_i,
  input  logic           rst,
  tournament_bp_if.slave bp
);

  localparam int MAX_GL  = (GHR_W > LHR_W) ? GHR_W : LHR_W;
  localparam int MAX_BC  = (BHT_IDX_W > CH_IDX_W) ? BHT_IDX_W : CH_IDX_W;
  localparam int SW_W    = (MAX_GL > MAX_BC) ? MAX_GL : MAX_BC;
  localparam int PC_IDX  = (GHR_W > MAX_BC) ? GHR_W : MAX_BC;

  if (PC_W < PC_IDX + 2) begin : g_bad_pc_w
    $error("tournament_bp: PC_W too small for the configured index widths");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  state_e            state_q, state_d;
  logic [SW_W-1:0]   sweep_q;
  logic [GHR_W-1:0]  ghr_q;
  logic [31:0]       cnt_update_q, cnt_mispred_q;
  logic              run;

  logic [1:0]        gpht_q    [2**GHR_W];
  logic [1:0]        lpht_q    [2**LHR_W];
  logic [LHR_W-1:0]  bht_q     [2**BHT_IDX_W];
  logic [1:0]        chooser_q [2**CH_IDX_W];

  logic [PC_W-1:0]      f_pc, u_pc;
  logic [GHR_W-1:0]     f_gidx, u_gidx;
  logic [BHT_IDX_W-1:0] f_bidx, u_bidx;
  logic [LHR_W-1:0]     f_lidx, u_lidx;
  logic [CH_IDX_W-1:0]  f_cidx, u_cidx;
  logic                 pred_global, pred_local, pred_taken;
  logic                 g_ok, l_ok, u_final;
  logic                 unused_bits;

  assign run  = (state_q == ST_RUN);
  assign f_pc = bp.f_pc_i;
  assign u_pc = bp.u_pc_i;

  // Only the index fields of the PCs and the low bits of the repair snapshot matter.
  assign unused_bits = ^{f_pc, u_pc, bp.rec_ghr_i[GHR_W-1]};

  // Fetch-side lookup; reads see table contents before any same-cycle training write.
  assign f_gidx      = f_pc[GHR_W+1:2] ^ ghr_q;
  assign f_bidx      = f_pc[BHT_IDX_W+1:2];
  assign f_lidx      = bht_q[f_bidx];
  assign f_cidx      = f_pc[CH_IDX_W+1:2];
  assign pred_global = gpht_q[f_gidx][1];
  assign pred_local  = lpht_q[f_lidx][1];
  assign pred_taken  = chooser_q[f_cidx][1] ? pred_global : pred_local;

  assign bp.f_pred_global_o = run & pred_global;
  assign bp.f_pred_local_o  = run & pred_local;
  assign bp.f_pred_taken_o  = run & pred_taken;
  assign bp.f_ghr_o         = ghr_q;
  assign bp.init_busy_o     = ~run;
  assign bp.cnt_update_o    = cnt_update_q;
  assign bp.cnt_mispred_o   = cnt_mispred_q;

  // Commit-side lookup, indexed with the GHR snapshot that travelled with the branch.
  assign u_gidx  = u_pc[GHR_W+1:2] ^ bp.u_ghr_i;
  assign u_bidx  = u_pc[BHT_IDX_W+1:2];
  assign u_lidx  = bht_q[u_bidx];
  assign u_cidx  = u_pc[CH_IDX_W+1:2];
  assign g_ok    = (bp.u_pred_global_i == bp.u_taken_i);
  assign l_ok    = (bp.u_pred_local_i == bp.u_taken_i);
  assign u_final = chooser_q[u_cidx][1] ? bp.u_pred_global_i : bp.u_pred_local_i;

  always_ff @(posedge clk_i) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (&sweep_q) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst)          sweep_q <= '0;
    else if (!run)    sweep_q <= sweep_q + SW_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (run) begin
      if (bp.rec_valid_i)                         ghr_q <= {bp.rec_ghr_i[GHR_W-2:0], bp.rec_taken_i};
      else if (bp.f_valid_i && bp.f_is_branch_i)  ghr_q <= {ghr_q[GHR_W-2:0], pred_taken};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      cnt_update_q  <= '0;
      cnt_mispred_q <= '0;
    end else if (run && bp.u_valid_i) begin
      cnt_update_q <= cnt_update_q + 32'd1;
      if (u_final != bp.u_taken_i) cnt_mispred_q <= cnt_mispred_q + 32'd1;
    end
  end

  // NOTE: the tables have no reset so they map onto RAM; the INIT sweep clears them instead.
  always_ff @(posedge clk_i) begin
    if (!run) begin
      gpht_q[sweep_q[GHR_W-1:0]]        <= 2'b01;
      lpht_q[sweep_q[LHR_W-1:0]]        <= 2'b01;
      bht_q[sweep_q[BHT_IDX_W-1:0]]     <= '0;
      chooser_q[sweep_q[CH_IDX_W-1:0]]  <= 2'b10;
    end else if (bp.u_valid_i) begin
      gpht_q[u_gidx] <= sat2(gpht_q[u_gidx], bp.u_taken_i);
      lpht_q[u_lidx] <= sat2(lpht_q[u_lidx], bp.u_taken_i);
      bht_q[u_bidx]  <= {u_lidx[LHR_W-2:0], bp.u_taken_i};
      // Chooser moves only when exactly one component was right, toward that component.
      if (g_ok != l_ok) chooser_q[u_cidx] <= sat2(chooser_q[u_cidx], g_ok);
    end
  end

endmodule
